sap1_ram: RTL and testbench

//  16x8 program/data RAM for SAP-1; the consumer of the 4-bit address latched by the MAR.
//  Run mode: asynchronously reads mem[addr] and drives it onto the 8-bit W bus when CE_bar is low.

---
 rtl/sap1_pkg.sv | 13 +
 rtl/sap1_ram_loader.sv | 88 ++++++++
 rtl/sap1_ram.sv | 55 +++++
 tb/tb_sap1_ram.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 RAM definitions: default widths and the loader state encoding.
package sap1_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap1_ram_loader.sv
// Program-mode byte loader: tracks RUN/LOAD/FULL, the write pointer and the byte count,
// and emits one write strobe per accepted byte.
module sap1_ram_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              prog_i,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_ready_o,
  output logic              prog_done_o,
  output logic [ADDR_W:0]   prog_count_o,
  output logic              run_mode_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    done_d       = done_q;
    we_o         = 1'b0;
    prog_ready_o = 1'b0;
    case (state_q)
      RUN: begin
        if (prog_i) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        prog_ready_o = 1'b1;
        // Leaving program mode wins over a byte offered on the same edge.
        if (!prog_i) begin
          state_d = RUN;
        end else if (prog_valid_i) begin
          we_o    = 1'b1;
          ptr_d   = ADDR_W'(ptr_q + 1'b1);
          count_d = (ADDR_W + 1)'(count_q + 1'b1);
          if (ptr_q == LAST_ADDR) begin
            state_d = FULL;
            done_d  = 1'b1;
          end
        end
      end
      FULL: begin
        if (!prog_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign prog_done_o  = done_q;
  assign prog_count_o = count_q;
  assign run_mode_o   = (state_q == RUN);
  assign waddr_o      = ptr_q;
  assign wdata_o      = prog_data_i;

endmodule

// File: rtl/sap1_ram.sv
// SAP-1 16x8 RAM: storage array written by the sequential loader, read combinationally
// onto the tri-stated W bus in run mode.
module sap1_ram
  import sap1_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic              CE_bar,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_bus,
  input  logic              prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              run_mode;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  sap1_ram_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk_i        (CLK),
    .rst_n_i      (CLR_bar),
    .prog_i       (prog),
    .prog_valid_i (prog_valid),
    .prog_data_i  (prog_data),
    .prog_ready_o (prog_ready),
    .prog_done_o  (prog_done),
    .prog_count_o (prog_count),
    .run_mode_o   (run_mode),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata)
  );

  // Contents survive reset so an aborted load keeps the bytes already written.
  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign w_bus = (run_mode && !CE_bar) ? mem_q[addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sap1_ram.sv
// Bench for sap1_ram: a byte-level model of the load protocol checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_sap1_ram;

  logic       CLK = 1'b0;
  logic       CLR_bar = 1'b0;
  logic       CE_bar = 1'b1;
  logic [3:0] addr = 4'h0;
  wire  [7:0] w_bus;
  logic       prog = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_ready;
  logic       prog_done;
  logic [4:0] prog_count;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  // Model: phase 0 = run, 1 = loading, 2 = full
  int         m_phase = 0;
  int         m_count = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_mem [16];
  bit         m_known [16];

  sap1_ram dut (
    .CLK        (CLK),
    .CLR_bar    (CLR_bar),
    .CE_bar     (CE_bar),
    .addr       (addr),
    .w_bus      (w_bus),
    .prog       (prog),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_count (prog_count)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // An undriven bus reads as z on 4-state simulators and as 0 on 2-state ones;
  // every byte the bench loads is nonzero, so a driven value never looks floating.
  function automatic bit floating(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic check_hiz(input string name);
    checks++;
    if (floating(w_bus)) passes++;
    else $display("FAIL %s: w_bus driven %h, expected high-Z", name, w_bus);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
  end

  always @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      m_phase = 0;
      m_count = 0;
      m_done  = 1'b0;
    end else begin
      case (m_phase)
        0: if (prog) begin
             m_phase = 1;
             m_count = 0;
             m_done  = 1'b0;
           end
        1: if (!prog) m_phase = 0;
           else if (prog_valid) begin
             m_mem[m_count]   = prog_data;
             m_known[m_count] = 1'b1;
             m_count++;
             if (m_count == 16) begin
               m_phase = 2;
               m_done  = 1'b1;
             end
           end
        default: if (!prog) m_phase = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cyc_ready", {15'd0, prog_ready}, {15'd0, m_phase == 1});
      check("cyc_done",  {15'd0, prog_done},  {15'd0, m_done});
      check("cyc_count", {11'd0, prog_count}, 16'(m_count));
      if (m_phase == 0 && !CE_bar) begin
        if (m_known[addr]) check("cyc_wbus", {8'd0, w_bus}, {8'd0, m_mem[addr]});
      end else begin
        check_hiz("cyc_wbus_hiz");
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    // Reset with the bus disabled
    tick(); tick();
    CLR_bar = 1'b1;
    tick();
    cmp_en = 1'b1;
    check_hiz("rst_wbus");
    check("rst_ready", {15'd0, prog_ready}, 16'd0);
    check("rst_done",  {15'd0, prog_done},  16'd0);
    check("rst_count", {11'd0, prog_count}, 16'd0);

    // Full back-to-back load of 8'h10..8'h1F
    prog = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'(8'h10 + i);
      tick();
      check($sformatf("full_count_%0d", i), {11'd0, prog_count}, 16'(i + 1));
    end
    check("full_done",  {15'd0, prog_done},  16'd1);
    check("full_ready", {15'd0, prog_ready}, 16'd0);
    prog_data = 8'hEE;
    tick();
    check("extra_byte_count", {11'd0, prog_count}, 16'd16);
    CE_bar = 1'b0;
    #1 check_hiz("full_ce_hiz");
    prog_valid = 1'b0;
    prog = 1'b0;
    tick();
    addr = 4'h5;
    #1 check("read_addr5", {8'd0, w_bus}, 16'h0015);
    check("done_held", {15'd0, prog_done}, 16'd1);

    // Same-cycle read sweep
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1 check($sformatf("sweep_%0d", a), {8'd0, w_bus}, 16'(8'h10 + a));
      tick();
    end

    // Load with gaps: valid 1,0,1 writes two bytes; bus stays off while loading
    prog = 1'b1;
    addr = 4'h0;
    tick();
    check_hiz("load_ce_hiz");
    prog_valid = 1'b1; prog_data = 8'h30; tick();
    prog_valid = 1'b0; prog_data = 8'h31; tick();
    prog_valid = 1'b1; prog_data = 8'h32; tick();
    check("gap_count", {11'd0, prog_count}, 16'd2);
    prog_valid = 1'b0;
    prog = 1'b0;
    tick();
    addr = 4'h0; #1 check("gap_mem0", {8'd0, w_bus}, 16'h0030);
    addr = 4'h1; #1 check("gap_mem1", {8'd0, w_bus}, 16'h0032);
    addr = 4'h2; #1 check("gap_mem2", {8'd0, w_bus}, 16'h0012);
    tick();

    // Partial load A0..A2; prog drop with a byte offered writes nothing
    prog = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'(8'hA0 + i);
      tick();
    end
    prog = 1'b0;
    prog_data = 8'hFF;
    tick();
    prog_valid = 1'b0;
    check("partial_count", {11'd0, prog_count}, 16'd3);
    for (int a = 0; a < 4; a++) begin
      addr = 4'(a);
      #1 check($sformatf("partial_mem%0d", a), {8'd0, w_bus},
               (a < 3) ? 16'(8'hA0 + a) : 16'h0013);
    end
    tick();

    // Reset after the fifth byte of a new load
    prog = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'(8'h50 + i);
      tick();
    end
    prog_valid = 1'b0;
    prog = 1'b0;
    CLR_bar = 1'b0;
    #1;
    check("abort_count", {11'd0, prog_count}, 16'd0);
    check("abort_ready", {15'd0, prog_ready}, 16'd0);
    tick();
    CLR_bar = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      addr = 4'(a);
      #1 check($sformatf("abort_mem%0d", a), {8'd0, w_bus},
               (a < 5) ? 16'(8'h50 + a) : 16'h0015);
    end
    tick();
    CE_bar = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
